// File: rtl/collision_impulse_resolver_if.sv
// Handshake and data bundle for the collision impulse resolver.
// The slave modport is the resolver's view. The master modport is the view of
// whoever drives pairs in and consumes the resolved velocities.
interface collision_impulse_resolver_if #(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x0;
  logic signed [WIDTH-1:0] y0;
  logic signed [WIDTH-1:0] v0_x;
  logic signed [WIDTH-1:0] v0_y;
  logic signed [WIDTH-1:0] x1;
  logic signed [WIDTH-1:0] y1;
  logic signed [WIDTH-1:0] v1_x;
  logic signed [WIDTH-1:0] v1_y;
  logic signed [WIDTH-1:0] restitution;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] new_v0_x;
  logic signed [WIDTH-1:0] new_v0_y;
  logic signed [WIDTH-1:0] new_v1_x;
  logic signed [WIDTH-1:0] new_v1_y;
  logic                    impulse_applied;
  logic                    saturated;

  modport slave (
    input  in_valid, x0, y0, v0_x, v0_y, x1, y1, v1_x, v1_y, restitution, out_ready,
    output in_ready, out_valid, new_v0_x, new_v0_y, new_v1_x, new_v1_y,
           impulse_applied, saturated
  );

  modport master (
    output in_valid, x0, y0, v0_x, v0_y, x1, y1, v1_x, v1_y, restitution, out_ready,
    input  in_ready, out_valid, new_v0_x, new_v0_y, new_v1_x, new_v1_y,
           impulse_applied, saturated
  );
endinterface

// File: rtl/collision_impulse_resolver.sv
// Equal-mass two-ball collision resolver with a run-time restitution
// coefficient. It handles one pair per transaction and uses a single shared
// restoring divider. Separating pairs and coincident pairs are passed through
// unchanged.
module collision_impulse_resolver #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 30,
  parameter int DIV_CYCLES = WIDTH
) (
  input logic clk,
  input logic rst,
  collision_impulse_resolver_if.slave bus
);
  localparam int DW = WIDTH + 1;                        // difference width
  localparam int PW = 2 * WIDTH + 2;                    // full-precision product width
  localparam int RW = PW + FRAC_WIDTH + DIV_CYCLES;     // divider remainder width
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1) << FRAC_WIDTH;
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] V_MAX = PW'($signed(Q_MAX));
  localparam logic signed [PW-1:0] V_MIN = -V_MAX - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_DOT   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DIV   = 3'd4;
  localparam logic [2:0] S_SCALE = 3'd5;
  localparam logic [2:0] S_APPLY = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0] state;
  logic signed [WIDTH-1:0] c_x0, c_y0, c_v0x, c_v0y, c_x1, c_y1, c_v1x, c_v1y, c_e;
  logic signed [DW-1:0] dx, dy, dvx, dvy;
  logic signed [PW-1:0] dist2, dot;
  logic [RW-1:0] rem, dsh;
  logic [DIV_CYCLES-1:0] quo;
  logic [CW-1:0] cnt;
  logic q_sat;
  logic [WIDTH-1:0] j;
  logic signed [WIDTH-1:0] nv0x, nv0y, nv1x, nv1y;
  logic imp, sat;

  // Clips a full-precision velocity to the signed WIDTH range; the MSB of the result flags a clip.
  function automatic logic [WIDTH:0] clip(input logic signed [PW-1:0] v);
    if (v > V_MAX) return {1'b1, V_MAX[WIDTH-1:0]};
    if (v < V_MIN) return {1'b1, V_MIN[WIDTH-1:0]};
    return {1'b0, v[WIDTH-1:0]};
  endfunction

  logic [PW-1:0] dot_abs;
  logic [RW-1:0] num_init, den_init, sat_lim;
  logic skip;
  logic [WIDTH-1:0] e_c, q_eff, j_next;
  logic signed [DW-1:0] j_s;
  logic signed [PW-1:0] tx, ty;
  logic [WIDTH:0] r0x, r0y, r1x, r1y;

  assign bus.in_ready        = (state == S_IDLE);
  assign bus.out_valid       = (state == S_DONE);
  assign bus.new_v0_x        = nv0x;
  assign bus.new_v0_y        = nv0y;
  assign bus.new_v1_x        = nv1x;
  assign bus.new_v1_y        = nv1y;
  assign bus.impulse_applied = imp;
  assign bus.saturated       = sat;

  // Divider set-up. The quotient saturates exactly when |dot|*2^F >= dist2 * 2^(WIDTH-1).
  assign dot_abs  = dot[PW-1] ? PW'(-dot) : PW'(dot);
  assign num_init = RW'(dot_abs) << FRAC_WIDTH;
  assign den_init = RW'($unsigned(dist2)) << (DIV_CYCLES - 1);
  assign sat_lim  = RW'($unsigned(dist2)) << (WIDTH - 1);
  assign skip     = (dist2 == '0) || !dot[PW-1];

  // Impulse magnitude and its projection back onto the contact normal.
  assign q_eff  = q_sat ? Q_MAX : WIDTH'(quo);
  assign j_next = WIDTH'(((2*WIDTH)'(q_eff) * (2*WIDTH)'(ONE + e_c)) >> (FRAC_WIDTH + 1));
  assign j_s    = $signed({1'b0, j});
  assign tx     = (PW'(j_s) * PW'(dx)) >>> FRAC_WIDTH;
  assign ty     = (PW'(j_s) * PW'(dy)) >>> FRAC_WIDTH;
  assign r0x    = clip(PW'(c_v0x) - tx);
  assign r0y    = clip(PW'(c_v0y) - ty);
  assign r1x    = clip(PW'(c_v1x) + tx);
  assign r1y    = clip(PW'(c_v1y) + ty);

  // Clamp restitution to [0, ONE].
  // NOTE: every branch of a combinational block must assign its outputs; assigning a default first guarantees no latch.
  always_comb begin
    e_c = c_e;
    if (c_e < 0)                 e_c = '0;
    else if (c_e > $signed(ONE)) e_c = ONE;
  end

  // Control FSM and result registers; these are the only registers reset.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      nv0x  <= '0;
      nv0y  <= '0;
      nv1x  <= '0;
      nv1y  <= '0;
      imp   <= 1'b0;
      sat   <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (bus.in_valid) state <= S_PREP;
        S_PREP:  state <= S_DOT;
        S_DOT:   state <= S_CHECK;
        S_CHECK: begin
          if (skip) begin
            nv0x  <= c_v0x;
            nv0y  <= c_v0y;
            nv1x  <= c_v1x;
            nv1y  <= c_v1y;
            imp   <= 1'b0;
            sat   <= 1'b0;
            state <= S_DONE;
          end else begin
            state <= S_DIV;
          end
        end
        S_DIV:   if (cnt == '0) state <= S_SCALE;
        S_SCALE: state <= S_APPLY;
        S_APPLY: begin
          nv0x  <= r0x[WIDTH-1:0];
          nv0y  <= r0y[WIDTH-1:0];
          nv1x  <= r1x[WIDTH-1:0];
          nv1y  <= r1y[WIDTH-1:0];
          imp   <= 1'b1;
          sat   <= q_sat | r0x[WIDTH] | r0y[WIDTH] | r1x[WIDTH] | r1y[WIDTH];
          state <= S_DONE;
        end
        S_DONE:  if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath pipeline: capture, differences, dot products, restoring divide, impulse scale.
  // NOTE: datapath registers have no reset; each is written before it is read in every transaction.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          c_x0  <= bus.x0;
          c_y0  <= bus.y0;
          c_v0x <= bus.v0_x;
          c_v0y <= bus.v0_y;
          c_x1  <= bus.x1;
          c_y1  <= bus.y1;
          c_v1x <= bus.v1_x;
          c_v1y <= bus.v1_y;
          c_e   <= bus.restitution;
        end
      end
      S_PREP: begin
        dx  <= DW'(c_x1) - DW'(c_x0);
        dy  <= DW'(c_y1) - DW'(c_y0);
        dvx <= DW'(c_v1x) - DW'(c_v0x);
        dvy <= DW'(c_v1y) - DW'(c_v0y);
      end
      S_DOT: begin
        dist2 <= PW'(dx) * PW'(dx) + PW'(dy) * PW'(dy);
        dot   <= PW'(dvx) * PW'(dx) + PW'(dvy) * PW'(dy);
      end
      S_CHECK: begin
        rem   <= num_init;
        dsh   <= den_init;
        quo   <= '0;
        cnt   <= CW'(DIV_CYCLES - 1);
        q_sat <= (num_init >= sat_lim);
      end
      S_DIV: begin
        if (rem >= dsh) begin
          rem <= rem - dsh;
          quo <= {quo[DIV_CYCLES-2:0], 1'b1};
        end else begin
          quo <= {quo[DIV_CYCLES-2:0], 1'b0};
        end
        dsh <= dsh >> 1;
        cnt <= cnt - 1'b1;
      end
      S_SCALE: j <= j_next;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_collision_impulse_resolver.sv
// Self-checking bench for collision_impulse_resolver (Q16.16 build).
// Results are predicted by a wide-integer behavioural model. A compare process
// checks the outputs on every cycle in which they are valid. Directed cases
// also pin literal values.
module tb_collision_impulse_resolver;
  localparam int W  = 32;
  localparam int F  = 16;
  localparam int DC = W;
  localparam int LAT_SKIP = 3;
  localparam int LAT_IMP  = DC + 5;
  localparam logic signed [W-1:0] ONE = 32'sd65536;

  typedef logic signed [199:0] big_t;
  typedef struct {
    logic signed [W-1:0] x0, y0, v0x, v0y, x1, y1, v1x, v1y, e;
  } pair_t;
  typedef struct {
    logic signed [W-1:0] v0x, v0y, v1x, v1y;
    logic imp, sat;
    int   lat;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  collision_impulse_resolver_if #(.WIDTH(W)) bus();
  collision_impulse_resolver #(.WIDTH(W), .FRAC_WIDTH(F), .DIV_CYCLES(DC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int    n_vec = 0;
  int    n_err = 0;
  res_t  exp_r;
  bit    exp_armed = 1'b0;
  string cur_tag = "";

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [W-1:0] clip(input big_t v, output bit c);
    big_t hi = (big_t'(1) <<< (W - 1)) - 1;
    big_t lo = -(big_t'(1) <<< (W - 1));
    c = 1'b0;
    if (v > hi) begin c = 1'b1; return hi[W-1:0]; end
    if (v < lo) begin c = 1'b1; return lo[W-1:0]; end
    return v[W-1:0];
  endfunction

  // Reference: equal-mass impulse along the normal, using wide exact arithmetic.
  function automatic res_t model(input pair_t p);
    res_t r;
    big_t dx, dy, dvx, dvy, dist2, dot, q, ec, j, tx, ty, one_b, qmax;
    bit c0, c1, c2, c3;
    one_b = big_t'(1) <<< F;
    qmax  = (big_t'(1) <<< (W - 1)) - 1;
    dx  = p.x1 - p.x0;
    dy  = p.y1 - p.y0;
    dvx = p.v1x - p.v0x;
    dvy = p.v1y - p.v0y;
    dist2 = dx * dx + dy * dy;
    dot   = dvx * dx + dvy * dy;
    if (dist2 == 0 || dot >= 0) begin
      r.v0x = p.v0x; r.v0y = p.v0y; r.v1x = p.v1x; r.v1y = p.v1y;
      r.imp = 1'b0; r.sat = 1'b0; r.lat = LAT_SKIP;
      return r;
    end
    q = ((-dot) <<< F) / dist2;
    r.sat = 1'b0;
    if (q > qmax) begin q = qmax; r.sat = 1'b1; end
    ec = p.e;
    if (ec < 0) ec = 0;
    else if (ec > one_b) ec = one_b;
    j  = (q * (one_b + ec)) >>> (F + 1);
    tx = (j * dx) >>> F;
    ty = (j * dy) >>> F;
    r.v0x = clip(p.v0x - tx, c0);
    r.v0y = clip(p.v0y - ty, c1);
    r.v1x = clip(p.v1x + tx, c2);
    r.v1y = clip(p.v1y + ty, c3);
    r.sat = r.sat | c0 | c1 | c2 | c3;
    r.imp = 1'b1;
    r.lat = LAT_IMP;
    return r;
  endfunction

  // Compare process: outputs must match the model on every valid cycle (including held cycles).
  always @(negedge clk) begin
    if (exp_armed && bus.out_valid === 1'b1) begin
      check({cur_tag, ":new_v0_x"}, bus.new_v0_x, exp_r.v0x);
      check({cur_tag, ":new_v0_y"}, bus.new_v0_y, exp_r.v0y);
      check({cur_tag, ":new_v1_x"}, bus.new_v1_x, exp_r.v1x);
      check({cur_tag, ":new_v1_y"}, bus.new_v1_y, exp_r.v1y);
      check({cur_tag, ":impulse_applied"}, bus.impulse_applied, exp_r.imp);
      check({cur_tag, ":saturated"}, bus.saturated, exp_r.sat);
    end
  end

  task automatic drive(input pair_t p);
    bus.x0 = p.x0;   bus.y0 = p.y0;   bus.v0_x = p.v0x; bus.v0_y = p.v0y;
    bus.x1 = p.x1;   bus.y1 = p.y1;   bus.v1_x = p.v1x; bus.v1_y = p.v1y;
    bus.restitution = p.e;
  endtask

  function automatic logic signed [W-1:0] rnd(input bit wide);
    if (wide) return $signed($urandom);
    return $signed($urandom_range(0, 8 * 65536)) - 32'sd262144;
  endfunction

  function automatic pair_t rnd_pair(input bit wide);
    pair_t p;
    p.x0 = rnd(wide); p.y0 = rnd(wide); p.v0x = rnd(wide); p.v0y = rnd(wide);
    p.x1 = rnd(wide); p.y1 = rnd(wide); p.v1x = rnd(wide); p.v1y = rnd(wide);
    p.e  = $signed($urandom_range(0, 2 * 65536)) - 32'sd32768;
    return p;
  endfunction

  function automatic pair_t mk(input int x1, y1, v0x, v0y, v1x, v1y, e);
    pair_t p;
    p.x0 = '0; p.y0 = '0;
    p.x1 = x1; p.y1 = y1; p.v0x = v0x; p.v0y = v0y; p.v1x = v1x; p.v1y = v1y; p.e = e;
    return p;
  endfunction

  task automatic run_pair(input string tag, input pair_t p, input int hold, output res_t got);
    res_t m;
    int   lat;
    m = model(p);
    @(negedge clk);
    check({tag, ":in_ready_idle"}, bus.in_ready, 1);
    drive(p);
    bus.in_valid = 1'b1;
    exp_r = m;
    cur_tag = tag;
    exp_armed = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drive(rnd_pair(1'b1));
    check({tag, ":in_ready_busy"}, bus.in_ready, 0);
    lat = 0;
    for (int c = 1; c <= LAT_IMP + 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, ":latency"}, lat, m.lat);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ":in_ready_held"}, bus.in_ready, 0);
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    got.v0x = bus.new_v0_x; got.v0y = bus.new_v0_y;
    got.v1x = bus.new_v1_x; got.v1y = bus.new_v1_y;
    got.imp = bus.impulse_applied; got.sat = bus.saturated; got.lat = lat;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_armed = 1'b0;
    check({tag, ":out_valid_after_consume"}, bus.out_valid, 0);
    check({tag, ":in_ready_after_consume"}, bus.in_ready, 1);
  endtask

  function automatic bit near(input longint a, input longint b);
    return (a - b <= 2) && (b - a <= 2);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    res_t g;
    pair_t p;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:in_ready", bus.in_ready, 1);
    check("reset:out_valid", bus.out_valid, 0);
    check("reset:new_v0_x", bus.new_v0_x, 0);
    check("reset:new_v1_y", bus.new_v1_y, 0);
    check("reset:impulse_applied", bus.impulse_applied, 0);
    check("reset:saturated", bus.saturated, 0);
    rst = 1'b0;

    // Head-on exchange with 10 cycles of backpressure.
    run_pair("headon", mk(2 * 65536, 0, 65536, 0, 0, 0, 65536), 10, g);
    check("headon:lit_v0x", g.v0x, 0);
    check("headon:lit_v1x", g.v1x, 65536);
    check("headon:lit_imp", g.imp, 1);
    check("headon:lit_lat", g.lat, 37);

    run_pair("inelastic", mk(2 * 65536, 0, 65536, 0, 0, 0, 0), 0, g);
    check("inelastic:lit_v0x", g.v0x, 32768);
    check("inelastic:lit_v1x", g.v1x, 32768);
    run_pair("e_neg", mk(2 * 65536, 0, 65536, 0, 0, 0, -19661), 1, g);
    check("e_neg:lit_v0x", g.v0x, 32768);
    run_pair("e_big", mk(2 * 65536, 0, 65536, 0, 0, 0, 98304), 0, g);
    check("e_big:lit_v0x", g.v0x, 0);
    check("e_big:lit_v1x", g.v1x, 65536);

    run_pair("separating", mk(2 * 65536, 0, -65536, 0, 65536, 0, 65536), 2, g);
    check("separating:lit_v0x", g.v0x, -65536);
    check("separating:lit_v1x", g.v1x, 65536);
    check("separating:lit_imp", g.imp, 0);
    check("separating:lit_lat", g.lat, 3);
    run_pair("coincident", mk(0, 0, 65536, 0, 0, 0, 65536), 0, g);
    check("coincident:lit_v0x", g.v0x, 65536);
    check("coincident:lit_imp", g.imp, 0);

    run_pair("glancing", mk(65536, 65536, 65536, 0, 0, 0, 65536), 0, g);
    check("glancing:v0x_2lsb", near(g.v0x, 32768), 1);
    check("glancing:v0y_2lsb", near(g.v0y, -32768), 1);
    check("glancing:v1x_2lsb", near(g.v1x, 32768), 1);
    check("glancing:v1y_2lsb", near(g.v1y, 32768), 1);

    run_pair("qsat", mk(1, 0, 98304, 0, 0, 0, 65536), 0, g);
    check("qsat:lit_sat", g.sat, 1);
    check("qsat:lit_v0x", g.v0x, 65537);
    check("qsat:lit_v1x", g.v1x, 32767);

    // Reset in the middle of the divide aborts the transaction.
    @(negedge clk);
    drive(mk(2 * 65536, 0, 65536, 0, 0, 0, 65536));
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_div:out_valid", bus.out_valid, 0);
    check("rst_div:in_ready", bus.in_ready, 1);
    check("rst_div:new_v0_x", bus.new_v0_x, 0);
    check("rst_div:impulse_applied", bus.impulse_applied, 0);
    run_pair("after_rst", mk(2 * 65536, 0, 65536, 0, 0, 0, 65536), 0, g);
    check("after_rst:lit_v1x", g.v1x, 65536);

    // Reset together with in_valid: nothing is captured.
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_valid:in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    check("rst_valid:in_ready_next", bus.in_ready, 1);
    check("rst_valid:out_valid", bus.out_valid, 0);

    // Randomized pairs: small coordinates give many collisions; full-range values stress saturation.
    for (int i = 0; i < 60; i++) begin
      p = rnd_pair(i % 3 == 0);
      if (i % 4 == 1) begin
        p.v0x = p.v1x + 32'sd65536;
        p.x1  = p.x0 + 32'sd131072;
        p.y1  = p.y0;
      end
      run_pair($sformatf("rand%0d", i), p, i % 3, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
